// File: rtl/my_reset_pkg.sv
// Shared definitions for the reset sequencer: sequencer state encoding,
// the soft-reset counter width and a counter-width helper.
package my_reset_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2,
        SOFT = 2'd3
    } seq_state_e;

    localparam int REASON_W  = 8;
    localparam int RST_CNT_W = REASON_W;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/my_reset_sync.sv
// Reset synchronizer: asynchronous assert, synchronized deassert.
// Ports:
//   clk        - clock
//   rst_n      - raw asynchronous active-low reset
//   rst_pre_n  - second-to-last synchronizer stage; goes high one edge
//                before rst_sync_n so a sequencer can act on the same edge
//                that rst_sync_n rises
//   rst_sync_n - synchronized reset; rises on the SYNC_STAGES-th posedge
//                after rst_n rises
module my_reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_pre_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_pre_n  = sync_q[SYNC_STAGES-2];
    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/my_reset_sequencer.sv
// Reset sequencer: synchronizes rst_n, releases domain resets one by one
// with a fixed gap, and services a 4-phase soft-reset handshake.
// Ports:
//   clk          - single clock
//   rst_n        - asynchronous active-low reset
//   soft_rst_req - soft-reset request (4-phase)
//   soft_rst_ack - soft-reset acknowledge
//   rst_sync_n   - rst_n with synchronized deassertion
//   dom_rst_n    - per-domain resets, released bit 0 upward
//   seq_done     - high while every domain is released
//   cycle_cnt    - saturating count of cycles spent in RUN
//   reset_count  - accepted soft resets since rst_n, saturating at 255
module my_reset_sequencer
    import my_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int NUM_DOMAINS     = 3,
    parameter int RELEASE_GAP     = 16,
    parameter int SOFT_RST_CYCLES = 8,
    parameter int CNT_W           = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   soft_rst_req,
    output logic                   soft_rst_ack,
    output logic                   rst_sync_n,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   seq_done,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [RST_CNT_W-1:0]   reset_count
);

    localparam int GAP_W  = cnt_w(RELEASE_GAP);
    localparam int HOLD_W = cnt_w(SOFT_RST_CYCLES);
    localparam int IDX_W  = cnt_w(NUM_DOMAINS);

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic rst_pre_n;

    seq_state_e             state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;
    // Set while the current release sequence was started by a soft reset,
    // so only that sequence raises the acknowledge on completion.
    logic                   pend_q, pend_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d;
    logic [RST_CNT_W-1:0]   rcnt_q, rcnt_d;

    my_reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst_pre_n (rst_pre_n),
        .rst_sync_n(rst_sync_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            gap_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            cyc_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            cyc_q   <= cyc_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        ack_d   = ack_q;
        pend_d  = pend_q;
        cyc_d   = cyc_q;
        rcnt_d  = rcnt_q;

        // Acknowledge drops as soon as the requester withdraws.
        if (ack_q && !soft_rst_req) begin
            ack_d = 1'b0;
        end

        case (state_q)
            SYNC: begin
                // rst_pre_n high means rst_sync_n rises on this same edge.
                if (rst_pre_n) begin
                    state_d = GAP;
                    gap_d   = '0;
                    idx_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    dom_d[idx_q] = 1'b1;
                    gap_d        = '0;
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                        if (pend_q) begin
                            ack_d  = 1'b1;
                            pend_d = 1'b0;
                        end
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            RUN: begin
                if (soft_rst_req && !ack_q) begin
                    dom_d   = '0;
                    done_d  = 1'b0;
                    cyc_d   = '0;
                    pend_d  = 1'b1;
                    hold_d  = '0;
                    state_d = SOFT;
                    if (rcnt_q != '1) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            SOFT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = GAP;
                    gap_d   = '0;
                    idx_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign soft_rst_ack = ack_q;
    assign dom_rst_n    = dom_q;
    assign seq_done     = done_q;
    assign cycle_cnt    = cyc_q;
    assign reset_count  = rcnt_q;

endmodule

// File: tb/tb_my_reset_sequencer.sv
module tb_my_reset_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic        rsync;
    logic [2:0]  dom;
    logic        done;
    logic [31:0] cyc;
    logic [7:0]  rcnt;

    // Small instance: saturation of the 4-bit cycle counter, single domain,
    // and fast soft-reset turnaround for the 255 saturation of reset_count.
    logic        req2;
    logic        ack2;
    logic        rsync2;
    logic [0:0]  dom2;
    logic        done2;
    logic [3:0]  cyc2;
    logic [7:0]  rcnt2;

    int n_cmp = 0;
    int n_mis = 0;
    int k;
    int tmo = 0;

    my_reset_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst_req(req),
        .soft_rst_ack(ack),
        .rst_sync_n  (rsync),
        .dom_rst_n   (dom),
        .seq_done    (done),
        .cycle_cnt   (cyc),
        .reset_count (rcnt)
    );

    my_reset_sequencer #(
        .SYNC_STAGES    (2),
        .NUM_DOMAINS    (1),
        .RELEASE_GAP    (1),
        .SOFT_RST_CYCLES(1),
        .CNT_W          (4)
    ) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst_req(req2),
        .soft_rst_ack(ack2),
        .rst_sync_n  (rsync2),
        .dom_rst_n   (dom2),
        .seq_done    (done2),
        .cycle_cnt   (cyc2),
        .reset_count (rcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_rsync"}, rsync, 1'b0);
        chk({tag, "_dom"},   dom,   3'b000);
        chk({tag, "_done"},  done,  1'b0);
        chk({tag, "_ack"},   ack,   1'b0);
        chk({tag, "_cyc"},   cyc,   32'd0);
        chk({tag, "_rcnt"},  rcnt,  8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        req2  = 1'b0;

        // ---- Power-on ----
        #500;
        chk_all_reset("por_reset");
        #500;                 // t=1000, between edges at 995 and 1005
        rst_n = 1'b1;
        step(1);
        chk("por_rsync_e1", rsync, 1'b0);
        step(1);              // E0
        chk("por_rsync_e0", rsync, 1'b1);
        chk("por_dom_e0", dom, 3'b000);
        step(15);
        chk("por_dom_e15", dom, 3'b000);
        step(1);
        chk("por_dom_e16", dom, 3'b001);
        step(16);
        chk("por_dom_e32", dom, 3'b011);
        chk("por_done_e32", done, 1'b0);
        step(16);
        chk("por_dom_e48", dom, 3'b111);
        chk("por_done_e48", done, 1'b1);
        chk("por_cyc_e48", cyc, 32'd0);
        step(10);
        chk("por_cyc_e58", cyc, 32'd10);
        chk("por_ack_e58", ack, 1'b0);

        // ---- Soft reset, request held until ack ----
        req = 1'b1;
        step(1);              // S
        chk("soft_dom_s", dom, 3'b000);
        chk("soft_done_s", done, 1'b0);
        chk("soft_rcnt_s", rcnt, 8'd1);
        chk("soft_cyc_s", cyc, 32'd0);
        chk("soft_ack_s", ack, 1'b0);
        step(23);
        chk("soft_dom_s23", dom, 3'b000);
        step(1);
        chk("soft_dom_s24", dom, 3'b001);
        step(16);
        chk("soft_dom_s40", dom, 3'b011);
        step(15);
        chk("soft_ack_s55", ack, 1'b0);
        step(1);
        chk("soft_dom_s56", dom, 3'b111);
        chk("soft_done_s56", done, 1'b1);
        chk("soft_ack_s56", ack, 1'b1);
        chk("soft_rcnt_s56", rcnt, 8'd1);
        req = 1'b0;
        step(1);
        chk("soft_ack_s57", ack, 1'b0);
        chk("soft_cyc_s57", cyc, 32'd1);

        // ---- Hard reset, then a request during GAP is ignored ----
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_reset("hard_async");
        step(2);
        #4;
        rst_n = 1'b1;
        step(1);
        chk("gapreq_rsync_e1", rsync, 1'b0);
        step(1);              // E0
        chk("gapreq_rsync_e0", rsync, 1'b1);
        step(20);
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(10);
        chk("gapreq_dom_e31", dom, 3'b001);
        chk("gapreq_rcnt_e31", rcnt, 8'd0);
        step(1);
        chk("gapreq_dom_e32", dom, 3'b011);
        step(16);
        chk("gapreq_dom_e48", dom, 3'b111);
        chk("gapreq_done_e48", done, 1'b1);
        chk("gapreq_rcnt_e48", rcnt, 8'd0);
        chk("gapreq_ack_e48", ack, 1'b0);

        // ---- Early request drop: one-cycle request ----
        req = 1'b1;
        step(1);              // S
        chk("early_rcnt_s", rcnt, 8'd1);
        chk("early_dom_s", dom, 3'b000);
        req = 1'b0;
        step(55);
        chk("early_dom_s55", dom, 3'b011);
        chk("early_ack_s55", ack, 1'b0);
        step(1);
        chk("early_dom_s56", dom, 3'b111);
        chk("early_ack_s56", ack, 1'b1);
        step(1);
        chk("early_ack_s57", ack, 1'b0);

        // ---- rst_n asserted 5 cycles into SOFT ----
        req = 1'b1;
        step(1);              // S2
        chk("abort_rcnt_s", rcnt, 8'd2);
        req = 1'b0;
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_reset("abort_async");
        step(3);
        chk("abort_ack_held", ack, 1'b0);
        #4;
        rst_n = 1'b1;
        step(2);              // E0
        chk("abort_rsync_e0", rsync, 1'b1);
        chk("abort_dom_e0", dom, 3'b000);
        step(1);
        chk("one_dom_e1", dom2, 1'b1);
        chk("one_done_e1", done2, 1'b1);
        chk("sat_cyc_e1", cyc2, 4'd0);
        step(14);
        chk("abort_dom_e15", dom, 3'b000);
        chk("sat_cyc_e15", cyc2, 4'd14);
        step(1);
        chk("abort_dom_e16", dom, 3'b001);
        chk("sat_cyc_e16", cyc2, 4'd15);
        step(32);
        chk("abort_dom_e48", dom, 3'b111);
        chk("abort_done_e48", done, 1'b1);
        chk("abort_ack_e48", ack, 1'b0);
        chk("abort_rcnt_e48", rcnt, 8'd0);
        chk("sat_cyc_e48", cyc2, 4'd15);
        step(10);
        chk("abort_cyc_e58", cyc, 32'd10);
        chk("abort_ack_e58", ack, 1'b0);

        // ---- 256 soft resets on the small instance ----
        for (int i = 0; i < 256; i++) begin
            req2 = 1'b1;
            k = 0;
            while (ack2 !== 1'b1 && k < 20) begin
                step(1);
                k++;
            end
            if (ack2 !== 1'b1) tmo++;
            if (i == 0) begin
                chk("sat_first_rcnt", rcnt2, 8'd1);
                chk("sat_first_cyc", cyc2, 4'd0);
                chk("sat_first_dom", dom2, 1'b1);
            end
            if (i == 254) chk("sat_rcnt_255", rcnt2, 8'd255);
            req2 = 1'b0;
            k = 0;
            while (ack2 !== 1'b0 && k < 20) begin
                step(1);
                k++;
            end
            if (ack2 !== 1'b0) tmo++;
        end
        chk("sat_rcnt_hold", rcnt2, 8'd255);
        chk("sat_handshake_timeouts", tmo, 0);
        chk("sat_main_rcnt_untouched", rcnt, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/my_reset_sequencer.md
Name: my_reset_sequencer

Overview:
Consumer end of the testbench clock/reset source. It takes the raw `clk` and asynchronous `rst_n` and produces a cleanly synchronized reset. It then releases per-domain resets in a fixed staggered order and supports a soft-reset request/acknowledge handshake. It sits between the clock/reset model and the DUT wrappers, and exposes cycle and reset-event counters for checkers.

Parameters:
SYNC_STAGES, 2, flops in the reset-deassertion synchronizer (legal: >=2)
NUM_DOMAINS, 3, number of sequenced domain resets (legal: >=1)
RELEASE_GAP, 16, clk cycles between successive domain releases (legal: >=1)
SOFT_RST_CYCLES, 8, clk cycles all domains are held in reset on a soft reset (legal: >=1)
CNT_W, 32, width of the run-cycle counter

Ports:
clk  input  1  single clock for the whole block
rst_n  input  1  asynchronous active-low reset
soft_rst_req  input  1  soft-reset request, 4-phase handshake
soft_rst_ack  output  1  soft-reset acknowledge
rst_sync_n  output  1  rst_n with asynchronous assert and synchronized deassert
dom_rst_n  output  NUM_DOMAINS  per-domain active-low resets, released in order from bit 0 upward
seq_done  output  1  high while all domains are released
cycle_cnt  output  CNT_W  clk cycles spent in RUN, saturating
reset_count  output  8  accepted soft resets since rst_n, saturating at 255

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is `rst_n`, asynchronous and active-low. No other clock or reset input exists.
- On `rst_n` low, immediately and asynchronously:
  - `rst_sync_n` = 0, `dom_rst_n` = all 0
  - `seq_done` = 0, `soft_rst_ack` = 0
  - `cycle_cnt` = 0, `reset_count` = 0
  - FSM = SYNC
- Synchronizer: after `rst_n` rises, `rst_sync_n` rises on the SYNC_STAGES-th `clk` posedge; call that edge E0. Any `rst_n` glitch low restarts everything from reset.
- FSM states: SYNC, GAP, RUN, SOFT (enum in package).
  - SYNC -> GAP on edge E0. The gap counter loads 0; the domain index loads 0.
  - GAP: the gap counter increments every cycle. When it reaches RELEASE_GAP-1, the next edge sets `dom_rst_n[idx]` = 1, clears the counter and increments idx.
  - Release timing: domain k rises at E0 + (k+1)*RELEASE_GAP. With defaults: E0+16, E0+32, E0+48.
  - Last-domain release: on the edge that releases the last domain, `seq_done` = 1 and FSM -> RUN. Released domains stay released.
  - RUN: `cycle_cnt` increments by 1 each edge from the edge after `seq_done` rises. It saturates at all-ones with no wrap.
  - Soft-reset accept: on an edge in RUN with `soft_rst_req` = 1 and `soft_rst_ack` = 0, that same edge (edge S) registers:
    - `dom_rst_n` = all 0, `seq_done` = 0, `cycle_cnt` = 0
    - `reset_count` += 1, saturating at 255
    - FSM -> SOFT with the hold counter at 0
  - SOFT: `dom_rst_n` stays all 0 for SOFT_RST_CYCLES cycles. At edge S+SOFT_RST_CYCLES, FSM -> GAP with the counter and idx at 0. Domain 0 then releases at S+SOFT_RST_CYCLES+RELEASE_GAP.
  - `rst_sync_n` is unaffected by soft reset.
- Handshake (4-phase):
  - `soft_rst_ack` rises on the same edge `seq_done` re-rises after a soft reset. It never rises after a power-on (`rst_n`) sequence.
  - `soft_rst_ack` falls on the first edge where `soft_rst_req` is sampled 0 while ack = 1.
  - If `soft_rst_req` drops before the sequence completes, ack still rises at completion and falls the following edge.
  - A new request is accepted only in RUN with ack = 0.
  - `soft_rst_req` is ignored in SYNC, GAP and SOFT, with no queuing.
- Mid-operation: `rst_n` assertion during GAP or SOFT aborts the sequence asynchronously, and no pending ack survives.
- NUM_DOMAINS=1: the single domain releases at E0+RELEASE_GAP together with `seq_done`.
- All outputs are registered. There are no combinational paths from inputs to outputs other than the async reset.

Decomposition:
- Shared package `my_reset_pkg`:
  - `seq_state_e` typedef (SYNC, GAP, RUN, SOFT)
  - `REASON_W`/`RST_CNT_W` = 8 constant
  - localparam helpers for counter widths ($clog2 of RELEASE_GAP, SOFT_RST_CYCLES, NUM_DOMAINS)
- Sub-module `my_reset_sync`: parameterized by SYNC_STAGES; inputs `clk` and `rst_n`, output `rst_sync_n`. It is instantiated once; the FSM, counters and handshake stay in the top.

Test Plan:
- Power-on with defaults, `rst_n` released at t=1000 between edges -> `rst_sync_n` high at 2nd posedge (E0); `dom_rst_n` 3'b001/011/111 at E0+16/32/48; `seq_done` at E0+48; `cycle_cnt`=10 at E0+58; ack stays 0.
- Soft reset: `soft_rst_req`=1 at edge S in RUN, dropped after ack -> `dom_rst_n`=0, `seq_done`=0, `reset_count`=1, `cycle_cnt`=0 at S; domains at S+24/40/56; ack=1 at S+56, 0 one edge after req drops.
- Request outside RUN: `soft_rst_req` pulsed during GAP at E0+20 -> ignored; `reset_count`=0; release timing identical to the power-on case.
- Early req drop: req high 1 cycle in RUN -> sequence completes; ack high exactly one cycle at S+56.
- `rst_n` asserted 5 cycles into SOFT -> all outputs 0 asynchronously; ack never rises; re-release gives the power-on timing with `reset_count`=0.
- Saturation: CNT_W=4, run 20 cycles -> `cycle_cnt` holds 15; 256 soft resets -> `reset_count` holds 255.
